// File: rtl/cache_traffic_gen.sv
`default_nettype none
// ============================================================================
// cache_traffic_gen : write-then-read cache traffic generator with in-order read-data check.
// Optional feature macro: CACHE_TG_CHECK_EN (read-data compare and err_cnt).
// Message layout: req  = {type_[2:0], opaque[7:0], addr[31:0], len[1:0], data[31:0]}
//                 resp = {type_[2:0], opaque[7:0], test[1:0], len[1:0], data[31:0]}
// Revision: 1.0 - initial release
// ============================================================================
module cache_traffic_gen #(
    parameter int unsigned WORD_NUM  = 16,
    parameter logic [31:0] BASE_ADDR = 32'h0,
    parameter int unsigned MAX_OUTST = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        cachereq_val,
    input  logic        cachereq_rdy,
    output logic [76:0] cachereq_msg,
    input  logic        cacheresp_val,
    output logic        cacheresp_rdy,
    input  logic [46:0] cacheresp_msg,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] err_cnt,
    output logic        proto_err
);

    localparam int unsigned        c_CNT_W      = $clog2(WORD_NUM + 1);
    localparam logic [c_CNT_W-1:0] c_WORD_LAST  = c_CNT_W'(WORD_NUM - 1);
    localparam logic [c_CNT_W-1:0] c_WORDS      = c_CNT_W'(WORD_NUM);
    localparam logic [c_CNT_W-1:0] c_ONE        = c_CNT_W'(1);
    localparam logic [3:0]         c_MAX_OUTST  = 4'(MAX_OUTST);
    localparam logic [2:0]         c_TYPE_READ  = 3'd0;
    localparam logic [2:0]         c_TYPE_WRITE = 3'd1;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WR       = 3'd1,
        S_WR_DRAIN = 3'd2,
        S_RD       = 3'd3,
        S_RD_DRAIN = 3'd4,
        S_DONE     = 3'd5
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [c_CNT_W-1:0] r_issued;
    logic [3:0]         r_outst;
    logic               r_proto;
    logic               r_resp_rdy;

    logic               w_req_fire;
    logic               w_resp_fire;
    logic               w_resp_ok;
    logic               w_last_req;
    logic               w_start_ok;
    logic               w_req_phase;
    logic [31:0]        w_addr;
    logic               w_unused;

    assign w_req_phase  = (r_state == S_WR) || (r_state == S_RD);
    assign cachereq_val = w_req_phase && (r_issued < c_WORDS) && (r_outst < c_MAX_OUTST);
    assign w_req_fire   = cachereq_val && cachereq_rdy;
    assign w_resp_fire  = cacheresp_val && r_resp_rdy;
    // A response with nothing outstanding is a protocol error and must not underflow the count.
    assign w_resp_ok    = w_resp_fire && (r_outst != 4'd0);
    assign w_last_req   = w_req_fire && (r_issued == c_WORD_LAST);
    assign w_start_ok   = start && ((r_state == S_IDLE) || (r_state == S_DONE));

    assign w_addr       = BASE_ADDR + (32'(r_issued) << 2);

    always_comb begin
        cachereq_msg = '0;
        if (cachereq_val) begin
            if (r_state == S_WR) begin
                cachereq_msg = {c_TYPE_WRITE, 8'd0, w_addr, 2'd0, w_addr};
            end else begin
                cachereq_msg = {c_TYPE_READ, 8'd0, w_addr, 2'd0, 32'd0};
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: if (start)              w_next = S_WR;
            S_WR:           if (w_last_req)         w_next = S_WR_DRAIN;
            S_WR_DRAIN:     if (r_outst == 4'd0)    w_next = S_RD;
            S_RD:           if (w_last_req)         w_next = S_RD_DRAIN;
            S_RD_DRAIN:     if (r_outst == 4'd0)    w_next = S_DONE;
            default:                                w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_issued   <= '0;
            r_outst    <= 4'd0;
            r_proto    <= 1'b0;
            r_resp_rdy <= 1'b0;
        end else begin
            r_resp_rdy <= 1'b1;
            // The issue index wraps to 0 on the last request so the read phase starts at word 0.
            if (w_req_fire) begin
                r_issued <= w_last_req ? '0 : r_issued + c_ONE;
            end
            case ({w_req_fire, w_resp_ok})
                2'b10:   r_outst <= r_outst + 4'd1;
                2'b01:   r_outst <= r_outst - 4'd1;
                default: r_outst <= r_outst;
            endcase
            if (w_resp_fire && (r_outst == 4'd0)) begin
                r_proto <= 1'b1;
            end else if (w_start_ok && (r_state == S_DONE)) begin
                r_proto <= 1'b0;
            end
        end
    end

    assign cacheresp_rdy = r_resp_rdy;
    assign busy          = (r_state == S_WR) || (r_state == S_WR_DRAIN) ||
                           (r_state == S_RD) || (r_state == S_RD_DRAIN);
    assign done          = (r_state == S_DONE);
    assign proto_err     = r_proto;

`ifdef CACHE_TG_CHECK_EN
    logic [c_CNT_W-1:0] r_rd_idx;
    logic [15:0]        r_err_cnt;
    logic               w_rd_resp;
    logic [31:0]        w_exp_data;

    assign w_rd_resp  = w_resp_ok && ((r_state == S_RD) || (r_state == S_RD_DRAIN));
    assign w_exp_data = BASE_ADDR + (32'(r_rd_idx) << 2);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rd_idx  <= '0;
            r_err_cnt <= 16'd0;
        end else if (w_start_ok) begin
            r_rd_idx  <= '0;
            r_err_cnt <= 16'd0;
        end else if (w_rd_resp) begin
            r_rd_idx <= r_rd_idx + c_ONE;
            if ((cacheresp_msg[31:0] != w_exp_data) && (r_err_cnt != 16'hFFFF)) begin
                r_err_cnt <= r_err_cnt + 16'd1;
            end
        end
    end

    assign err_cnt  = r_err_cnt;
    assign pass     = done && !r_proto && (r_err_cnt == 16'd0);
    assign w_unused = ^cacheresp_msg[46:32];
`else
    assign err_cnt  = 16'd0;
    assign pass     = done && !r_proto;
    assign w_unused = ^cacheresp_msg;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cache_traffic_gen.sv
`default_nettype none
// Randomised bench: in-bench cache with random ready/latency plus a transaction-level
// model of the expected request stream, outstanding limit, error count and status.
module tb_cache_traffic_gen;
    localparam int          W    = 6;
    localparam logic [31:0] BASE = 32'h40;
    localparam int          MO   = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        cachereq_rdy = 1'b0;
    logic        cacheresp_val = 1'b0;
    logic [46:0] cacheresp_msg = '0;
    logic        cachereq_val, cacheresp_rdy, busy, done, pass, proto_err;
    logic [76:0] cachereq_msg;
    logic [15:0] err_cnt;

    cache_traffic_gen #(.WORD_NUM(W), .BASE_ADDR(BASE), .MAX_OUTST(MO)) dut (
        .clk(clk), .rst(rst), .start(start),
        .cachereq_val(cachereq_val), .cachereq_rdy(cachereq_rdy), .cachereq_msg(cachereq_msg),
        .cacheresp_val(cacheresp_val), .cacheresp_rdy(cacheresp_rdy), .cacheresp_msg(cacheresp_msg),
        .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt), .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    int vec = 0;
    int mis = 0;
    int cyc = 0;

    int run_st;   // 0 idle, 1 running, 2 finished
    int idx, outst, err_exp, last_due;
    bit proto_exp;
    int pend_due[$];
    int pend_k[$];
    logic [31:0] pend_data[$];
    logic [31:0] mem [logic [31:0]];

    int rdy_pct, lat_max, corrupt, hold_rdy, stall_end;
    bit read_hold;
    bit prev_val, prev_acc;
    logic [76:0] first_msg, last_msg;

    task automatic chk(input string name, input logic [76:0] got, input logic [76:0] exp);
        vec++;
        if (got !== exp) begin
            mis++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    function automatic logic [76:0] exp_msg(input int k);
        logic [31:0] a;
        if (k < W) begin
            a = BASE + 32'(4 * k);
            return {3'd1, 8'd0, a, 2'd0, a};
        end
        a = BASE + 32'(4 * (k - W));
        return {3'd0, 8'd0, a, 2'd0, 32'd0};
    endfunction

    function automatic logic exp_pass();
`ifdef CACHE_TG_CHECK_EN
        return (err_exp == 0) && !proto_exp;
`else
        return !proto_exp;
`endif
    endfunction

    function automatic logic [15:0] err_out();
`ifdef CACHE_TG_CHECK_EN
        return 16'(err_exp);
`else
        return 16'd0;
`endif
    endfunction

    task automatic model_clear();
        run_st = 0; idx = 0; outst = 0; err_exp = 0; proto_exp = 1'b0; last_due = 0;
        pend_due.delete(); pend_k.delete(); pend_data.delete();
        prev_val = 1'b0; prev_acc = 1'b0;
        hold_rdy = 0; read_hold = 1'b0; stall_end = 0;
    endtask

    task automatic chk_reset_vals();
        chk("rst_req_val", cachereq_val, 1'b0);
        chk("rst_req_msg", cachereq_msg, 77'd0);
        chk("rst_resp_rdy", cacheresp_rdy, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_pass", pass, 1'b0);
        chk("rst_err_cnt", err_cnt, 16'd0);
        chk("rst_proto_err", proto_err, 1'b0);
    endtask

    task automatic cycle(input bit do_start, input bit spurious);
        logic        req_acc, rsp_acc;
        logic [31:0] a, d;
        int          k, due;
        @(negedge clk);
        cyc++;
        chk("resp_rdy", cacheresp_rdy, 1'b1);
        chk("proto_err", proto_err, proto_exp);
        chk("err_cnt", err_cnt, err_out());
        if (prev_val && !prev_acc) chk("val_hold", cachereq_val, 1'b1);
        if (cachereq_val) begin
            chk("val_legal", (run_st == 1) && (idx < 2 * W) && (outst < MO), 1'b1);
            chk("req_msg", cachereq_msg, exp_msg(idx));
        end
        if (run_st == 1) begin
            if (done) begin
                chk("done_all_req", idx, 2 * W);
                chk("done_outst", outst, 0);
                chk("done_busy", busy, 1'b0);
                chk("done_pass", pass, exp_pass());
                run_st = 2;
            end else begin
                chk("run_busy", busy, 1'b1);
            end
        end else if (run_st == 2) begin
            chk("fin_done", done, 1'b1);
            chk("fin_busy", busy, 1'b0);
            chk("fin_pass", pass, exp_pass());
        end else begin
            chk("idle_busy", busy, 1'b0);
            chk("idle_done", done, 1'b0);
            chk("idle_pass", pass, 1'b0);
        end

        if (hold_rdy > 0) begin
            cachereq_rdy = 1'b0;
            if (cachereq_val) hold_rdy--;
        end else begin
            cachereq_rdy = (int'($urandom_range(99)) < rdy_pct);
        end
        if (spurious) begin
            cacheresp_val = 1'b1;
            cacheresp_msg = {15'd0, 32'($urandom)};
        end else if (pend_k.size() > 0 && pend_due[0] <= cyc && cyc >= stall_end &&
                     !(read_hold && pend_k[0] >= W)) begin
            cacheresp_val = 1'b1;
            cacheresp_msg = {(pend_k[0] < W) ? 3'd1 : 3'd0, 8'd0, 2'd0, 2'd0, pend_data[0]};
        end else begin
            cacheresp_val = 1'b0;
            cacheresp_msg = {15'd0, 32'($urandom)};
        end
        start = do_start;

        req_acc = cachereq_val && cachereq_rdy;
        rsp_acc = cacheresp_val && cacheresp_rdy;
        if (req_acc && idx == W) chk("rd_after_drain", outst, 0);
        if (rsp_acc) begin
            if (outst == 0) begin
                proto_exp = 1'b1;
            end else begin
                outst--;
                k   = pend_k.pop_front();
                d   = pend_data.pop_front();
                due = pend_due.pop_front();
                if (k >= W && d != BASE + 32'(4 * (k - W))) err_exp++;
            end
        end
        if (req_acc) begin
            a = cachereq_msg[65:34];
            if (idx == 0) first_msg = cachereq_msg;
            if (idx == 2 * W - 1) last_msg = cachereq_msg;
            if (idx < W) begin
                mem[a] = cachereq_msg[31:0];
                d = 32'h0;
            end else if (idx - W == corrupt) begin
                d = 32'hDEAD;
            end else begin
                d = mem.exists(a) ? mem[a] : 32'h0;
            end
            due = cyc + int'($urandom_range(lat_max, 1));
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            pend_due.push_back(due);
            pend_k.push_back(idx);
            pend_data.push_back(d);
            idx++;
            outst++;
        end
        if (do_start && run_st != 1) begin
            if (run_st == 2) begin
                proto_exp = 1'b0;
                err_exp   = 0;
            end
            run_st = 1;
            idx    = 0;
        end
        prev_val = cachereq_val;
        prev_acc = req_acc;
    endtask

    task automatic run(input int p_rdy, input int p_lat, input int p_corrupt, input int p_hold,
                       input int p_stall, input int p_abort, input int p_midstart);
        int n;
        rdy_pct   = p_rdy;
        lat_max   = p_lat;
        corrupt   = p_corrupt;
        hold_rdy  = p_hold;
        read_hold = (p_abort > 0);
        stall_end = cyc + 1 + p_stall;
        cycle(1'b1, 1'b0);
        n = 0;
        while (run_st == 1 && n < 800) begin
            cycle(n == p_midstart, 1'b0);
            n++;
            if (p_stall > 0 && cyc == stall_end) begin
                chk("stall_accepts", idx, 4);
                chk("stall_val", cachereq_val, 1'b0);
            end
            if (p_abort > 0 && idx > W && outst == p_abort) begin
                @(posedge clk);
                #2 rst = 1'b0;
                #1 chk_reset_vals();
                cachereq_rdy  = 1'b0;
                cacheresp_val = 1'b0;
                start         = 1'b0;
                model_clear();
                repeat (2) @(negedge clk);
                chk_reset_vals();
                rst = 1'b1;
                return;
            end
        end
        if (run_st != 2) chk("run_timeout", 1'b0, 1'b1);
        start = 1'b0;
    endtask

    initial begin
        model_clear();
        corrupt = -1; rdy_pct = 100; lat_max = 1;
        #12;
        chk_reset_vals();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) cycle(1'b0, 1'b0);

        // Spurious response in IDLE, then a run whose result must be a fail.
        cycle(1'b0, 1'b1);
        cycle(1'b0, 1'b0);
        chk("spurious_proto", proto_err, 1'b1);
        run(100, 1, -1, 0, 0, 0, -1);
        chk("spurious_run_pass", pass, 1'b0);

        // Ideal cache, started from DONE: status cleared, clean pass.
        run(100, 1, -1, 0, 0, 0, -1);
        chk("ideal_pass", pass, 1'b1);
        chk("ideal_proto", proto_err, 1'b0);
        chk("ideal_first", first_msg, {3'd1, 8'd0, 32'h40, 2'd0, 32'h40});
        chk("ideal_last", last_msg, {3'd0, 8'd0, 32'h54, 2'd0, 32'd0});

        // Request not accepted for 5 cycles on the first write.
        run(100, 1, -1, 5, 0, 0, -1);
        chk("hold_first", first_msg, {3'd1, 8'd0, 32'h40, 2'd0, 32'h40});
        chk("hold_pass", pass, 1'b1);

        // Responses withheld: outstanding limit must stop issue at 4.
        run(100, 3, -1, 0, 12, 0, -1);
        chk("stall_pass", pass, 1'b1);

        // Corrupted read of word 2, plus a start pulse mid-run that must be ignored.
        run(60, 6, 2, 0, 0, 0, 3);
`ifdef CACHE_TG_CHECK_EN
        chk("corrupt_err_cnt", err_cnt, 16'd1);
        chk("corrupt_pass", pass, 1'b0);
`else
        chk("corrupt_err_cnt", err_cnt, 16'd0);
        chk("corrupt_pass", pass, 1'b1);
`endif

        for (int r = 0; r < 4; r++) begin
            run(30 + 20 * r, 1 + 2 * r, (r == 2) ? 4 : -1, 0, 0, 0, -1);
        end

        // Reset during the read phase with 3 requests outstanding, then a clean run.
        run(100, 2, -1, 0, 0, 3, -1);
        cycle(1'b0, 1'b0);
        run(70, 4, -1, 0, 0, 0, -1);
        chk("after_reset_pass", pass, 1'b1);
        chk("after_reset_err", err_cnt, 16'd0);
        repeat (2) cycle(1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/cache_traffic_gen.md
CACHE_TRAFFIC_GEN -- requirements
Module: cache_traffic_gen

Interface
REQ-001 Parameter WORD_NUM, default 16: number of 4-byte words per phase (1..1024).
REQ-002 Parameter BASE_ADDR, default 32'h0: byte address of word 0, 4-byte aligned.
REQ-003 Parameter MAX_OUTST, default 4: maximum outstanding requests (1..15).
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  one-cycle pulse that begins a write-then-read run.
REQ-007 cachereq_val  output  1  request valid.
REQ-008 cachereq_rdy  input  1  cache accepts request.
REQ-009 cachereq_msg  output  mem_req_4B_t  request: type_, opaque, addr, len, data.
REQ-010 cacheresp_val  input  1  response valid.
REQ-011 cacheresp_rdy  output  1  generator accepts response.
REQ-012 cacheresp_msg  input  mem_resp_4B_t  response; only data is used.
REQ-013 busy  output  1  run in progress.
REQ-014 done  output  1  run complete, held until next start.
REQ-015 pass  output  1  valid when done; 1 means err_cnt==0 and no protocol error.
REQ-016 err_cnt  output  16  read-data mismatches, saturating at 16'hFFFF.
REQ-017 proto_err  output  1  sticky: response arrived with zero outstanding.

Function
REQ-018 The FSM SHALL have states IDLE, WR, WR_DRAIN, RD, RD_DRAIN, DONE.
- IDLE/DONE to WR on start.
- WR to WR_DRAIN after WORD_NUM writes accepted.
- WR_DRAIN to RD when outstanding==0.
- RD to RD_DRAIN after WORD_NUM reads accepted.
- RD_DRAIN to DONE when outstanding==0.
REQ-019 A request is issued when cachereq_val && cachereq_rdy at a rising edge; cachereq_val and cachereq_msg SHALL hold stable until accepted.
REQ-020 Request i (0..WORD_NUM-1): addr = BASE_ADDR + 4*i, opaque=0, len=0.
- Writes: type_=WRITE, data=addr.
- Reads: type_=READ, data=0.
REQ-021 cachereq_val SHALL be asserted only in WR/RD, with issued count < WORD_NUM and outstanding < MAX_OUTST; the next request MAY issue in the cycle after acceptance (back-to-back).
REQ-022 cacheresp_rdy SHALL be 1 in every state except reset.
REQ-023 Outstanding counter: +1 on request accept, -1 on response accept; simultaneous accept and response SHALL leave it unchanged.
REQ-024 Read responses return in order; response j in the read phase SHALL be compared against BASE_ADDR + 4*j. A mismatch increments err_cnt by 1 in the cycle after the response.
REQ-025 A response with outstanding==0 SHALL set proto_err and leave the counter at 0.
REQ-026 busy=1 in WR, WR_DRAIN, RD, RD_DRAIN; done=1 only in DONE.
REQ-027 start while busy SHALL be ignored. start in DONE SHALL clear err_cnt, proto_err and done, then enter WR.

Reset
REQ-028 Asserting rst low SHALL force IDLE asynchronously, mid-run included, with all counters 0 and these outputs: cachereq_val=0, cachereq_msg=0, cacheresp_rdy=0, busy=0, done=0, pass=0, err_cnt=0, proto_err=0.
REQ-029 The first request SHALL appear no earlier than the second rising edge after rst deasserts and start pulses.

Configuration
REQ-030 Macro CACHE_TG_CHECK_EN:
- Defined: read-data compare and err_cnt are per REQ-024.
- Undefined: no compare logic; err_cnt tied 0; pass = done && !proto_err.

Verification
REQ-031 WORD_NUM=4, ideal cache (rdy=1, 1-cycle resp) -> writes addr 0,4,8,C with data=addr, then 4 reads; done=1, pass=1, err_cnt=0.
REQ-032 cachereq_rdy held 0 for 5 cycles on the first write -> val, addr=0 and data=0 held stable; no request lost or duplicated.
REQ-033 Cache withholds responses, MAX_OUTST=4 -> exactly 4 requests accepted, then val=0 until a response arrives.
REQ-034 Read of addr 8 returns 32'hDEAD -> err_cnt=1, pass=0 (with CACHE_TG_CHECK_EN); without the macro, err_cnt=0 and pass=1.
REQ-035 Spurious cacheresp_val in IDLE -> proto_err=1; after a run completes, pass=0.
REQ-036 rst low during RD with 3 outstanding -> IDLE immediately, all outputs at reset values; a new start runs a clean pass.
